// File: rtl/fpu_pkg.sv
// Shared FPU constants, canonical values and state encodings.
// Used by the normalise/pack stage and the add/sub datapath.
package fpu_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int FRAC_W   = 23;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    NP_IDLE,
    NP_NORM,
    NP_ROUND,
    NP_PACK,
    NP_DONE
  } np_state_e;

  typedef enum logic [1:0] {
    SD_IDLE,
    SD_ALIGN,
    SD_ADD,
    SD_DONE
  } sd_state_e;

endpackage

// File: rtl/fpu_normpack_pack.sv
// Combinational pack/saturation of sign, wide exponent and fraction.
// Also reusable by int-to-float conversion.
module fpu_pack
  import fpu_pkg::*;
(
  input  logic              sgn,
  input  logic signed [9:0] e,
  input  logic              zero,
  input  logic [FRAC_W-1:0] frac,
  output logic [31:0]       word,
  output logic              ovf,
  output logic              unf
);

  always_comb begin
    word = ZERO;
    ovf  = 1'b0;
    unf  = 1'b0;
    if (zero) begin
      word = ZERO;
    end else if (e >= 10'sd255) begin
      word = {sgn, 8'hFF, 23'h0};
      ovf  = 1'b1;
    end else if (e <= 10'sd0) begin
      word = {sgn, 31'h0};
      unf  = 1'b1;
    end else begin
      word = {sgn, e[7:0], frac};
    end
  end

endmodule

// File: rtl/fpu_normpack.sv
// Bit-serial normalise, round and pack to IEEE single.
// FPU_NORM_RNE_EN selects round-to-nearest-even, else truncation.
module fpu_normpack
  import fpu_pkg::*;
#(
  parameter int W  = 47,
  parameter int HB = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cs,
  output logic         ready,
  input  logic [W:0]   m_in,
  input  logic [7:0]   exp_in,
  input  logic         sgn_in,
  output logic [31:0]  result,
  output logic         ovf,
  output logic         unf
);

  localparam int LB = HB - FRAC_W;

  np_state_e state, state_nx;

  logic [W:0]        m;
  logic signed [9:0] e;
  logic              g, s, sgn;
  logic              above, low_nz, inc, carry;
  logic [W+1:0]      sum;
  logic              do_load, do_shr, do_shl;
  logic              do_rnd, do_pack;
  logic [31:0]       pk_word;
  logic              pk_ovf, pk_unf;

  assign above = |(m >> (HB + 1));

  generate
    if (LB == 0) begin : g_nolow
      assign low_nz = 1'b0;
    end else begin : g_low
      assign low_nz = |m[LB-1:0];
    end
  endgenerate

`ifdef FPU_NORM_RNE_EN
  assign inc = g & (s | low_nz | m[LB]);
`else
  assign inc = 1'b0;
`endif

  assign sum   = {1'b0, m} + ((W+2)'(inc) << LB);
  assign carry = sum[HB+1];

  always_ff @(posedge clk) begin
    if (rst) state <= NP_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      NP_IDLE:  if (cs) state_nx = NP_NORM;
      NP_NORM: begin
        if (m == '0)
          state_nx = NP_PACK;
        else if (!above && m[HB])
          state_nx = NP_ROUND;
      end
      NP_ROUND: state_nx = NP_PACK;
      NP_PACK:  state_nx = NP_DONE;
      NP_DONE:  if (!cs) state_nx = NP_IDLE;
      default:  state_nx = NP_IDLE;
    endcase
  end

  always_comb begin
    do_load = 1'b0;
    do_shr  = 1'b0;
    do_shl  = 1'b0;
    do_rnd  = 1'b0;
    do_pack = 1'b0;
    unique case (state)
      NP_IDLE:  do_load = cs;
      NP_NORM: begin
        do_shr = (m != '0) && above;
        do_shl = (m != '0) && !above && !m[HB];
      end
      NP_ROUND: do_rnd  = 1'b1;
      NP_PACK:  do_pack = 1'b1;
      default: ;
    endcase
  end

  fpu_pack u_pack (
    .sgn  (sgn),
    .e    (e),
    .zero (m == '0),
    .frac (m[HB-1:LB]),
    .word (pk_word),
    .ovf  (pk_ovf),
    .unf  (pk_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      m      <= '0;
      e      <= '0;
      g      <= 1'b0;
      s      <= 1'b0;
      sgn    <= 1'b0;
      ready  <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      ready <= (state == NP_DONE);
      if (do_load) begin
        m   <= m_in;
        e   <= {2'b00, exp_in};
        sgn <= sgn_in;
        g   <= 1'b0;
        s   <= 1'b0;
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (do_shr) begin
        m <= m >> 1;
        g <= m[0];
        s <= s | g;
        e <= e + 10'sd1;
      end
      if (do_shl) begin
        m <= {m[W-1:0], g};
        g <= 1'b0;
        e <= e - 10'sd1;
      end
      // Sub-fraction bits fold into sticky before packing.
      if (do_rnd) begin
        s <= s | low_nz;
        if (carry) begin
          m <= sum[W+1:1];
          e <= e + 10'sd1;
        end else begin
          m <= sum[W:0];
        end
      end
      if (do_pack) begin
        result <= pk_word;
        ovf    <= pk_ovf;
        unf    <= pk_unf;
      end
    end
  end

endmodule
